// File: rtl/ram_fifo_ctrl.sv
// rtl/ram_fifo_ctrl.sv - FIFO controller for an external dual-port RAM with a 2-entry output buffer
module ram_fifo_ctrl #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [ADDR_W-1:0] ram_waddr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_wen,
  output logic [ADDR_W-1:0] ram_raddr,
  output logic              ram_ren,
  input  logic [DATA_W-1:0] ram_rdata,
  input  logic [ADDR_W+1:0] ae_thresh,
  input  logic [ADDR_W+1:0] af_thresh,
  output logic [ADDR_W+1:0] count,
  output logic              empty,
  output logic              full,
  output logic              almost_empty,
  output logic              almost_full
);

  localparam logic [ADDR_W:0] DEPTH_P = {1'b1, {ADDR_W{1'b0}}};

  logic [ADDR_W:0]   wptr, rptr, ram_occ;
  logic              inflight;
  logic [1:0]        nb;
  logic [DATA_W-1:0] ob0, ob1;
  logic [ADDR_W+1:0] cnt;
  logic              push, pop;

  assign ram_occ = wptr - rptr;
  assign full    = (ram_occ == DEPTH_P);
  assign s_ready = !full && !flush && !rst;

  assign ram_wen   = s_valid && s_ready;
  assign ram_waddr = wptr[ADDR_W-1:0];
  assign ram_wdata = s_data;

  assign m_valid = (nb != 2'd0);
  assign m_data  = ob0;
  assign pop     = m_valid && m_ready;
  assign push    = inflight && !flush;

  // Issue only when the returning word is guaranteed an obuf slot at capture.
  assign ram_ren   = (ram_occ != '0) && !flush && !rst &&
                     (({1'b0, nb} + {2'b00, inflight}) < (3'd2 + {2'b00, pop}));
  assign ram_raddr = rptr[ADDR_W-1:0];

  assign count        = cnt;
  assign empty        = (cnt == '0);
  assign almost_empty = (cnt <= ae_thresh);
  assign almost_full  = (af_thresh != '0) && (cnt >= af_thresh);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr     <= '0;
      rptr     <= '0;
      inflight <= 1'b0;
      nb       <= 2'd0;
      ob0      <= '0;
      ob1      <= '0;
      cnt      <= '0;
    end else if (flush) begin
      wptr     <= '0;
      rptr     <= '0;
      inflight <= 1'b0;
      nb       <= 2'd0;
      cnt      <= '0;
    end else begin
      if (ram_wen) wptr <= wptr + 1'b1;
      if (ram_ren) rptr <= rptr + 1'b1;
      inflight <= ram_ren;
      cnt      <= cnt + {{(ADDR_W+1){1'b0}}, ram_wen} - {{(ADDR_W+1){1'b0}}, pop};
      case ({push, pop})
        2'b10: begin
          if (nb == 2'd0) ob0 <= ram_rdata;
          else            ob1 <= ram_rdata;
          nb <= nb + 2'd1;
        end
        2'b01: begin
          ob0 <= ob1;
          nb  <= nb - 2'd1;
        end
        2'b11: begin
          if (nb == 2'd1) begin
            ob0 <= ram_rdata;
          end else begin
            ob0 <= ob1;
            ob1 <= ram_rdata;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
